// File: rtl/decode_stage_if.sv
// IF -> ID -> EX bus for the decode stage: fetch handshake, write-back port,
// registered ID/EX fields and the debug LED tap.
interface decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       ins;
    logic [DATA_W-1:0] npc_i;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        op;
    logic [5:0]        func;
    logic [4:0]        rs_idx;
    logic [4:0]        rt_idx;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] imm;
    logic [25:0]       jpc;
    logic [4:0]        write_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] npc_o;
    logic [15:0]       debug_leds;

    modport slave (
        input  in_valid, ins, npc_i, flush, wb_en, wb_reg, wb_data, out_ready,
        output in_ready, out_valid, op, func, rs_idx, rt_idx, data_a, data_b,
               imm, jpc, write_reg, reg_write, mem_read, mem_write, npc_o, debug_leds
    );

    modport master (
        output in_valid, ins, npc_i, flush, wb_en, wb_reg, wb_data, out_ready,
        input  in_ready, out_valid, op, func, rs_idx, rt_idx, data_a, data_b,
               imm, jpc, write_reg, reg_write, mem_read, mem_write, npc_o, debug_leds
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset instruction decode stage: register file with write-back bypass,
// load-use stall, branch flush and a registered ID/EX output with valid/ready.
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int FORWARD_EN = 1,
    parameter int DEBUG_REG  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    decode_stage_if.slave   bus
);
    localparam logic [4:0] DBG_IDX = 5'(DEBUG_REG);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SW   = 6'h2B;

    logic [DATA_W-1:0] rf_q [32];

    logic              vld_q, vld_d;
    logic [5:0]        op_q, op_d, func_q, func_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, npc_q, npc_d;
    logic [25:0]       jpc_q, jpc_d;
    logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;

    logic [5:0]        dec_op;
    logic [4:0]        dec_rs, dec_rt, dec_wr;
    logic              dec_rw, dec_mr, dec_mw, dec_uses_rt;
    logic              hazard, accept, wb_live;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        logic signed [15:0] s;
        s = v;
        return DATA_W'(s);
    endfunction

    // r0 is hard-wired; a same-cycle write-back wins over the stored value when bypassing
    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        if (FORWARD_EN != 0 && bus.wb_en && bus.wb_reg == idx)
            return bus.wb_data;
        return rf_q[idx];
    endfunction

    assign dec_op = bus.ins[31:26];
    assign dec_rs = bus.ins[25:21];
    assign dec_rt = bus.ins[20:16];

    always_comb begin
        dec_wr      = 5'd0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_uses_rt = 1'b0;
        case (dec_op)
            OP_RTYPE: begin dec_wr = bus.ins[15:11]; dec_rw = 1'b1; dec_uses_rt = 1'b1; end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_wr = dec_rt; dec_rw = 1'b1;
            end
            OP_LB, OP_LW: begin dec_wr = dec_rt; dec_rw = 1'b1; dec_mr = 1'b1; end
            OP_SB, OP_SW: begin dec_mw = 1'b1; dec_uses_rt = 1'b1; end
            OP_BEQ, OP_BNE: dec_uses_rt = 1'b1;
            OP_JAL: begin dec_wr = 5'd31; dec_rw = 1'b1; end
            default: ;
        endcase
    end

    // A load in ID/EX whose result the incoming instruction needs costs one bubble
    assign hazard = vld_q && mr_q && wr_q != 5'd0 &&
                    (wr_q == dec_rs || (dec_uses_rt && wr_q == dec_rt));
    assign bus.in_ready = !bus.flush && !hazard && (!vld_q || bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready;
    assign wb_live = bus.wb_en && bus.wb_reg != 5'd0;

    always_comb begin
        vld_d = vld_q; op_d = op_q; func_d = func_q; rs_d = rs_q; rt_d = rt_q;
        a_d = a_q; b_d = b_q; imm_d = imm_q; jpc_d = jpc_q; wr_d = wr_q;
        rw_d = rw_q; mr_d = mr_q; mw_d = mw_q; npc_d = npc_q;
        if (bus.flush) begin
            vld_d = 1'b0;
        end else if (accept) begin
            vld_d  = 1'b1;
            op_d   = dec_op;
            func_d = bus.ins[5:0];
            rs_d   = dec_rs;
            rt_d   = dec_rt;
            a_d    = read_reg(dec_rs);
            b_d    = read_reg(dec_rt);
            imm_d  = sext16(bus.ins[15:0]);
            jpc_d  = bus.ins[25:0];
            wr_d   = dec_wr;
            rw_d   = dec_rw;
            mr_d   = dec_mr;
            mw_d   = dec_mw;
            npc_d  = bus.npc_i;
        end else if (bus.out_ready) begin
            vld_d = 1'b0;
        end else if (vld_q && FORWARD_EN != 0 && wb_live) begin
            // keep stalled operands coherent with registers written while EX is busy
            if (bus.wb_reg == rs_q) a_d = bus.wb_data;
            if (bus.wb_reg == rt_q) b_d = bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_live) begin
            rf_q[bus.wb_reg] <= bus.wb_data;
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0; op_q <= '0; func_q <= '0; rs_q <= '0; rt_q <= '0;
            a_q <= '0; b_q <= '0; imm_q <= '0; jpc_q <= '0; wr_q <= '0;
            rw_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0; npc_q <= '0;
        end else begin
            vld_q <= vld_d; op_q <= op_d; func_q <= func_d; rs_q <= rs_d; rt_q <= rt_d;
            a_q <= a_d; b_q <= b_d; imm_q <= imm_d; jpc_q <= jpc_d; wr_q <= wr_d;
            rw_q <= rw_d; mr_q <= mr_d; mw_q <= mw_d; npc_q <= npc_d;
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.op         = op_q;
    assign bus.func       = func_q;
    assign bus.rs_idx     = rs_q;
    assign bus.rt_idx     = rt_q;
    assign bus.data_a     = a_q;
    assign bus.data_b     = b_q;
    assign bus.imm        = imm_q;
    assign bus.jpc        = jpc_q;
    assign bus.write_reg  = wr_q;
    assign bus.reg_write  = rw_q;
    assign bus.mem_read   = mr_q;
    assign bus.mem_write  = mw_q;
    assign bus.npc_o      = npc_q;
    assign bus.debug_leds = rf_q[DBG_IDX][DATA_W-1 -: 16];
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode pipeline stage: MIPS-subset decoder, 32-entry register file with write-back bypass, and a registered ID/EX output with valid/ready handshake. Adds load-use hazard stall, branch flush, and refresh of held operands while EX is back-pressuring. Sits between the IF stage (instruction + next PC) and the EX stage; the write-back port comes from WB.

## Interface
- DATA_W, 32, register/operand width; must be ≥16; imm sign-extended to DATA_W
- FORWARD_EN, 1, 1 = same-cycle write-back bypass into operand reads and held-operand refresh; 0 = plain read of stored value
- DEBUG_REG, 8, register index whose bits [DATA_W-1:DATA_W-16] drive debug_leds
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  stage accepts it this cycle
- ins  in  32  instruction word
- npc_i  in  DATA_W  next PC of ins
- flush  in  1  branch/jump redirect; squash stage contents
- wb_en, wb_reg, wb_data  in  1/5/DATA_W  register write-back port
- out_valid  out  1  ID/EX register holds a live instruction
- out_ready  in  1  EX consumes it this cycle
- op, func  out  6/6  ins[31:26], ins[5:0]
- rs_idx, rt_idx  out  5/5  ins[25:21], ins[20:16]
- data_a, data_b  out  DATA_W  rs/rt operands
- imm  out  DATA_W  sign-extended ins[15:0]
- jpc  out  26  ins[25:0]
- write_reg  out  5  destination register
- reg_write, mem_read, mem_write  out  1  control
- npc_o  out  DATA_W  npc_i of the held instruction
- debug_leds  out  16  see DEBUG_REG

## Operation
- Decode: R-type (op 000000) → write_reg=rd, reg_write=1. ADDI/ADDIU/ANDI/ORI/XORI/LUI → write_reg=rt, reg_write=1. LW/LB → write_reg=rt, reg_write=1, mem_read=1. SW/SB → mem_write=1. JAL → write_reg=31, reg_write=1. BEQ/BNE/BGTZ/J/unknown → all controls 0, write_reg=0.
- Regfile: write at edge when wb_en && wb_reg≠0. Register 0 always reads 0. All registers clear on reset.
- Read: with FORWARD_EN=1 and wb_en && wb_reg==index≠0, operand = wb_data; otherwise the stored value.
- Uses rt: R-type, BEQ, BNE, SW, SB. All other decoded ops use rs only; J/JAL use neither.
- hazard = out_valid && mem_read && write_reg≠0 && (write_reg==ins rs || (uses rt && write_reg==ins rt)).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the ID/EX register loads the decoded fields, out_valid=1.
- Drain without accept (out_ready && !accept): out_valid←0. A hazard thus inserts exactly one bubble.
- Hold (out_valid && !out_ready): all fields hold. With FORWARD_EN=1, a write-back to held rs_idx/rt_idx (≠0) updates data_a/data_b at that edge.
- Flush: out_valid←0 at the edge, and no accept that cycle. Flush has priority over hold and accept. Write-back still happens.

## Timing
- Latency 1: instruction accepted at edge N is visible on outputs after edge N.
- Throughput: 1 instruction/cycle with no hazard. Load-use costs 1 cycle.
- Reset (asynchronous assert): out_valid=0, all out fields 0, all registers 0, debug_leds=0. in_ready=1 once rst_n=1 and flush=0.
- in_ready is combinational from out_valid, out_ready, flush and ins.
- Reset mid-hold discards the held instruction immediately.
- Simultaneous write-back and accept of the same register: the bypassed value is captured when FORWARD_EN=1; the stale value is captured when FORWARD_EN=0.

## Test plan
- After reset, write wb r8=32'hABCD_1234, then ADDI r9,r8,5 with out_ready=1 → debug_leds=16'hABCD; next cycle data_a=32'hABCD_1234, imm=5, write_reg=9, reg_write=1.
- Same-cycle bypass: wb r3=7 in the cycle ADD r4,r3,r3 is accepted → data_a=data_b=7. Repeat with FORWARD_EN=0 → old value 0.
- Load-use: LW r5,0(r1) accepted, then ADD r6,r5,r2 presented → in_ready=0 for 1 cycle, one bubble (out_valid=0), ADD out next cycle. Same test with ADD r6,r2,r0 → no stall.
- Back-pressure: hold SW r2 with out_ready=0 for 3 cycles while wb writes r2=99 → data_b=99, other fields unchanged, in_ready=0.
- Flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle, the instruction is not accepted, the concurrent wb is committed.
- Write to r0 with wb_data=5 → a later read of r0 gives 0. Edge cases: BEQ with imm 16'h8000 → imm=32'hFFFF_8000; JAL → write_reg=31.
